// File: rtl/ahb_lite_uart_rx.sv
// AHB-Lite slave that receives 8N1 serial bytes into a FIFO. It exposes a
// pop-on-read RXDATA register and a STATUS register with sticky write-1-to-clear flags.
module ahb_lite_uart_rx #(
  parameter int CLKS_PER_BIT = 434,
  parameter int FIFO_AW      = 4
) (
  input  logic        HCLK,
  input  logic        HRESET,
  input  logic [31:0] HADDR,
  input  logic        HSEL,
  input  logic [1:0]  HTRANS,
  input  logic        HWRITE,
  input  logic [31:0] HWDATA,
  output logic [31:0] HRDATA,
  output logic        HREADY,
  output logic        HRESP,
  input  logic        UART_RX
);
  localparam int CW    = $clog2(CLKS_PER_BIT);
  localparam int DEPTH = 1 << FIFO_AW;
  localparam logic [CW-1:0]    BIT_LAST  = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0]    HALF_LAST = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [FIFO_AW:0] FULL_CNT  = (FIFO_AW + 1)'(DEPTH);

  typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_e;

  state_e              state_q, state_d;
  logic [CW-1:0]       cnt_q, cnt_d;
  logic [2:0]          bitidx_q, bitidx_d;
  logic [7:0]          shift_q, shift_d;
  logic                sync1_q, rx_s_q, rx_d_q, rx_fall;
  logic                push, frame_set;

  logic                wr_pend_q;
  logic [1:0]          addr_q;
  logic [31:0]         hrdata_q, rd_mux, status;
  logic                bus_sel, rd_req, pop, wr_status;

  logic [7:0]          mem [DEPTH];
  logic [FIFO_AW-1:0]  wr_ptr_q, rd_ptr_q;
  logic [FIFO_AW:0]    count_q;
  logic                full, not_empty, push_ok, ovf_set;
  logic                frame_err_q, overrun_q;

  logic                unused_bits;
  assign unused_bits = ^{HADDR[31:4], HADDR[1:0], HTRANS[0], HWDATA[31:4], HWDATA[1:0]};

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      sync1_q <= 1'b1;
      rx_s_q  <= 1'b1;
      rx_d_q  <= 1'b1;
    end else begin
      sync1_q <= UART_RX;
      rx_s_q  <= sync1_q;
      rx_d_q  <= rx_s_q;
    end
  end
  assign rx_fall = rx_d_q & ~rx_s_q;

  always_ff @(posedge HCLK) begin
    if (HRESET) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (rx_fall) state_d = S_START;
      S_START: if (cnt_q == HALF_LAST) state_d = rx_s_q ? S_IDLE : S_DATA;
      S_DATA:  if (cnt_q == BIT_LAST && bitidx_q == 3'd7) state_d = S_STOP;
      S_STOP:  if (cnt_q == BIT_LAST) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    cnt_d     = cnt_q + 1'b1;
    bitidx_d  = bitidx_q;
    shift_d   = shift_q;
    push      = 1'b0;
    frame_set = 1'b0;
    case (state_q)
      S_IDLE: cnt_d = '0;
      S_START: if (cnt_q == HALF_LAST) begin
        cnt_d    = '0;
        bitidx_d = '0;
      end
      S_DATA: if (cnt_q == BIT_LAST) begin
        cnt_d    = '0;
        shift_d  = {rx_s_q, shift_q[7:1]};
        bitidx_d = bitidx_q + 1'b1;
      end
      S_STOP: if (cnt_q == BIT_LAST) begin
        cnt_d     = '0;
        push      = rx_s_q;
        frame_set = ~rx_s_q;
      end
      default: cnt_d = '0;
    endcase
  end

  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      cnt_q    <= '0;
      bitidx_q <= '0;
      shift_q  <= '0;
    end else begin
      cnt_q    <= cnt_d;
      bitidx_q <= bitidx_d;
      shift_q  <= shift_d;
    end
  end

  assign full      = (count_q == FULL_CNT);
  assign not_empty = (count_q != '0);
  assign status    = {27'b0, not_empty, frame_err_q, overrun_q, full, not_empty};

  assign bus_sel   = HSEL & HTRANS[1];
  assign rd_req    = bus_sel & ~HWRITE;
  assign pop       = rd_req & (HADDR[3:2] == 2'd0) & not_empty;
  assign wr_status = wr_pend_q & (addr_q == 2'd1);

  // A push into a full FIFO still lands if the same edge frees a slot.
  assign push_ok   = push & (~full | pop);
  assign ovf_set   = push & full & ~pop;

  always_comb begin
    rd_mux = '0;
    case (HADDR[3:2])
      2'd0:    rd_mux = not_empty ? {23'b0, 1'b1, mem[rd_ptr_q]} : 32'h0;
      2'd1:    rd_mux = status;
      default: rd_mux = '0;
    endcase
  end

  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      wr_pend_q <= 1'b0;
      addr_q    <= '0;
      hrdata_q  <= '0;
    end else begin
      wr_pend_q <= bus_sel & HWRITE;
      if (bus_sel) addr_q <= HADDR[3:2];
      if (rd_req)  hrdata_q <= rd_mux;
    end
  end

  // Set wins over a simultaneous write-1-to-clear.
  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      frame_err_q <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      frame_err_q <= frame_set | (frame_err_q & ~(wr_status & HWDATA[3]));
      overrun_q   <= ovf_set   | (overrun_q   & ~(wr_status & HWDATA[2]));
    end
  end

  // NOTE: storage is not reset; only pointers and count define which entries are valid.
  always_ff @(posedge HCLK) begin
    if (push_ok) mem[wr_ptr_q] <= shift_q;
  end

  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push_ok) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)     rd_ptr_q <= rd_ptr_q + 1'b1;
      case ({push_ok, pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  assign HRDATA = hrdata_q;
  assign HREADY = 1'b1;
  assign HRESP  = 1'b0;
endmodule

// File: doc/ahb_lite_uart_rx.md
# ahb_lite_uart_rx

AHB-Lite slave that receives 8N1 serial bytes on `UART_RX`, buffers them in a FIFO, and exposes data and status registers to the CPU. It is the receive-side counterpart of the UART transmitter and attaches to one slave port of the AHB-Lite matrix. Its `HSEL` comes from the matrix decoder. Its `HRDATA` and `HRESP` feed the response mux, and its `HREADY` is ANDed into the bus `HREADY`.

## Interface
Reset is synchronous and active-high on a single clock (`HCLK`).

Parameters:
- `CLKS_PER_BIT`, default 434: `HCLK` cycles per bit (50 MHz / 115200). Must be at least 4.
- `FIFO_AW`, default 4: FIFO depth is 2^`FIFO_AW` entries (16).

Ports:
- `HCLK` input 1: bus and receiver clock.
- `HRESET` input 1: synchronous, active-high reset.
- `HADDR` input 32: byte address. Only `HADDR[3:2]` is decoded.
- `HSEL` input 1: slave select from the decoder.
- `HTRANS` input 2: transfer type. Only `HTRANS[1]` (NONSEQ/SEQ) is used.
- `HWRITE` input 1: 1 = write.
- `HWDATA` input 32: write data, valid in the data phase.
- `HRDATA` output 32: read data, registered.
- `HREADY` output 1: constant 1 (zero wait states).
- `HRESP` output 1: constant 0 (OKAY).
- `UART_RX` input 1: asynchronous serial input, idle high.

## Operation
- **Address phase**: `HSEL & HTRANS[1]` sampled at a rising edge. `HADDR[3:2]` and `HWRITE` are latched at that edge for the data phase.
- **Register map**:
  - 0x0 RXDATA (read-only): returns {23'b0, valid, byte[7:0]}. valid=1 and the byte is the FIFO head if the FIFO is non-empty, otherwise 0x000. Reading a non-empty FIFO pops one entry. Writes are ignored.
  - 0x4 STATUS: {27'b0, count_nz, frame_err, overrun, full, not_empty}. `frame_err` (bit 3) and `overrun` (bit 2) are sticky. `count_nz` (bit 4) equals `not_empty`. A write clears each sticky bit whose `HWDATA` bit is 1 (write-1-to-clear, applied in the data phase).
  - 0x8, 0xC: read 0, writes ignored.
- **Read path**: `HRDATA` is loaded at the address-phase edge from the addressed register and holds until the next selected read. For RXDATA, the pop occurs at that same edge.
- **Synchronizer**: `UART_RX` passes through two flops (reset value 1), giving `rx_s`. Falling-edge detection uses `rx_s` and a delayed copy of it.
- **Receiver FSM** (`cnt` is a bit-timer, `bitidx` is 0..7):
  - IDLE: on an `rx_s` 1→0 transition → START, `cnt`=0.
  - START: when `cnt`==`CLKS_PER_BIT/2`-1: if `rx_s`==0 → DATA with `cnt`=0 and `bitidx`=0; else → IDLE (glitch rejected).
  - DATA: when `cnt`==`CLKS_PER_BIT`-1, shift `rx_s` in LSB-first and reset `cnt`. After bit 7 → STOP.
  - STOP: when `cnt`==`CLKS_PER_BIT`-1: if `rx_s`==1, push the byte; else set `frame_err` and discard the byte. → IDLE in both cases.
  - A break (line held low) produces at most one frame error, because IDLE requires a new falling edge.
- **FIFO**: circular buffer with `FIFO_AW`-bit pointers and a (`FIFO_AW`+1)-bit count. Pointers wrap modulo the depth.
  - Push while full: the byte is dropped, `overrun` is set, and the FIFO is unchanged.
  - Push and pop in the same cycle while full: both take effect, no overrun, count unchanged.
  - Push and pop in the same cycle while empty: impossible, since a pop requires non-empty as sampled before the edge. The push succeeds.

## Timing
- **Reset values**: `HRDATA`=0, `HREADY`=1, `HRESP`=0. The FSM is in IDLE, the FIFO is empty, sticky bits are 0, and the synchronizer flops are 1.
- **Read latency**: the address phase is at cycle N and data is valid on `HRDATA` throughout cycle N+1. There are never wait states.
- **Back-to-back reads** of RXDATA pop consecutive entries. The second read sees the state after the first pop.
- **Read of STATUS** returns flags as they stood before the edge of its address phase.
- **Receive latency**: the push occurs about 9.5×`CLKS_PER_BIT`+2 cycles after the start-bit falling edge on `UART_RX`. `not_empty` is visible one cycle after the push.
- **Flag timing**: a sticky-clear write in the same cycle as a new sticky event leaves the flag set (set wins).
- **Reset mid-frame**: `HRESET` asserted during a frame aborts it. Nothing is pushed, and the receiver waits for a new falling edge.

## Test plan
- **Basic receive**: with `CLKS_PER_BIT`=8, send 0xA5 at 8 clk/bit. Then: STATUS reads 0x11; RXDATA reads 0x1A5; STATUS then reads 0x00; a further RXDATA read returns 0x000.
- **Ordering and wrap**: send 20 bytes 0x00–0x13 while reading continuously. All are returned in order with valid=1 across the pointer wrap, and STATUS has no overrun.
- **Overrun**: send 17 bytes with no reads. STATUS reads 0x17 (full, not_empty, overrun). 16 RXDATA reads return 0x00–0x0F, then 0x000. Writing 0x4 to STATUS clears overrun.
- **Frame error and glitch**: a frame with stop bit 0 sets `frame_err` (STATUS=0x08) with nothing pushed. A 2-cycle low glitch causes no push and no error.
- **Full with simultaneous push/pop**: fill to 16 entries, then read RXDATA on the same edge as the 17th push. No overrun, count stays 16, and ordering is preserved.
- **Reset mid-frame**: pulse `HRESET` during the DATA bits. All registers return to reset values, and the next full frame 0x3C is received correctly.
